// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches between BTB lookup and branch resolution.
// Resolves oldest-first, emits registered BTB update / fetch redirect pulses, flushes on mispredict.
module branch_resolve_queue #(
  parameter int DEPTH   = 4,
  parameter int AW      = 16,
  parameter int PC_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [AW-1:0]            enq_pc,
  input  logic                     enq_pred_taken,
  input  logic [AW-1:0]            enq_pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [AW-1:0]            res_target,
  output logic                     redirect_valid,
  output logic [AW-1:0]            redirect_pc,
  output logic                     upd_valid,
  output logic [AW-1:0]            upd_pc,
  output logic [AW-1:0]            upd_target,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          tk;
    logic [AW-1:0] tgt;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq_fire, res_fire, mispred;
  ent_t          hd;
  logic [AW-1:0] fix_pc;

  logic          upd_valid_q, upd_taken_q, redir_valid_q, err_q;
  logic [AW-1:0] upd_pc_q, upd_tgt_q, redir_pc_q;

  assign hd        = mem_q[head_q];
  assign enq_ready = (cnt_q < FULL);
  assign enq_fire  = enq_valid && enq_ready;
  // Resolve sees occupancy before any same-cycle enqueue.
  assign res_fire  = res_valid && (cnt_q != '0);
  assign mispred   = res_fire && ((hd.tk != res_taken) ||
                                  (hd.tk && res_taken && (hd.tgt != res_target)));
  assign fix_pc    = res_taken ? res_target : hd.pc + AW'(PC_STEP);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (mispred) begin
      // Everything younger is wrong-path, including a same-cycle enqueue.
      head_d = tail_q;
      cnt_d  = '0;
    end else begin
      if (res_fire) head_d = head_q + PW'(1);
      if (enq_fire) tail_d = tail_q + PW'(1);
      case ({enq_fire, res_fire})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire && !mispred) mem_q[tail_q] <= '{pc: enq_pc, tk: enq_pred_taken, tgt: enq_pred_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      cnt_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_tgt_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      upd_valid_q   <= res_fire;
      redir_valid_q <= mispred;
      if (res_fire) begin
        upd_pc_q    <= hd.pc;
        upd_tgt_q   <= res_target;
        upd_taken_q <= res_taken;
      end
      if (mispred) redir_pc_q <= fix_pc;
      if (res_valid && cnt_q == '0) err_q <= 1'b1;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_target     = upd_tgt_q;
  assign upd_taken      = upd_taken_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign count          = cnt_q;
  assign err_underflow  = err_q;
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, placed between fetch (BTB lookup) and execute (branch resolution).
- Fetch enqueues each predicted branch: PC, predicted direction and predicted target.
- Execute resolves branches oldest-first. The block detects mispredictions, issues a fetch redirect, flushes younger entries, and drives the BTB update port (write index, target, taken strobe).

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- AW, 16, address width of PCs and targets.
- PC_STEP, 1, fall-through increment added to PC for not-taken redirects.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enq_valid  in  1  fetch presents a predicted branch.
- enq_ready  out  1  queue can accept this cycle.
- enq_pc  in  AW  branch instruction address.
- enq_pred_taken  in  1  BTB prediction (hit ⇒ taken).
- enq_pred_target  in  AW  BTB predicted target.
- res_valid  in  1  execute resolves the oldest branch.
- res_taken  in  1  actual direction.
- res_target  in  AW  actual taken target.
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  AW  corrected fetch address.
- upd_valid  out  1  one-cycle pulse: BTB write request.
- upd_pc  out  AW  BTB write address (branch PC).
- upd_target  out  AW  BTB write target.
- upd_taken  out  1  BTB write enable qualifier (taken outcome).
- count  out  log2(DEPTH)+1  current occupancy.
- err_underflow  out  1  sticky: resolve arrived with the queue empty.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and count cleared.
  - All outputs 0, except enq_ready=1.
  - A reset mid-operation discards all entries and any pending pulse.
- Storage: circular buffer with head/tail pointers, wrapping modulo DEPTH. Each entry holds {pc, pred_taken, pred_target}.
- enq_ready = (count < DEPTH), combinational from registered count. A full queue never accepts, even if a resolve occurs the same cycle (no bypass).
- Enqueue fires when enq_valid & enq_ready: write at tail, tail+1.
- Resolve fires when res_valid & count≠0: pop head, head+1.
  - The resolve is evaluated against occupancy before any same-cycle enqueue.
  - res_valid with count=0: sets err_underflow (cleared only by reset); no pop, no pulses.
- Mispredict is determined at resolve from the head entry:
  - (pred_taken ≠ res_taken), or
  - (pred_taken & res_taken & pred_target ≠ res_target).
- Outputs are registered: one cycle latency from the resolve cycle.
  - upd_valid=1, upd_pc=head.pc, upd_taken=res_taken and upd_target=res_target on every resolve.
  - If mispredicted, additionally:
    - redirect_valid=1.
    - redirect_pc = res_taken ? res_target : head.pc + PC_STEP (mod 2^AW).
  - Pulses last exactly one cycle. upd_*/redirect_pc hold their last value when the strobes are low.
- Flush on mispredict, in the resolve cycle:
  - All younger entries are discarded: head=tail, count=0.
  - A same-cycle enqueue is dropped; those instructions are wrong-path.
- Occupancy:
  - Simultaneous enqueue and non-mispredicting resolve: count unchanged.
  - Enqueue alone: count+1.
  - Resolve alone: count−1.
- Correct predictions produce no redirect, and the queue keeps its younger entries.

Test Plan:
- Reset then idle: count=0, enq_ready=1, all pulses 0. Assert rst_n=0 mid-fill with 3 entries → count=0 immediately, no pulse after release.
- Fill: enqueue PCs 0x0010,0x0020,0x0030,0x0040 (pred not-taken) → count=4, enq_ready=0. A 5th enq_valid is ignored. Resolve with res_taken=0 ×4 → four upd_valid pulses with upd_pc 0x0010..0x0040 in order, upd_taken=0, no redirect, count=0.
- Direction mispredict: entries 0x0100 (pred taken → 0x0200) and 0x0104. Resolve res_taken=0 → next cycle redirect_valid=1, redirect_pc=0x0101, upd_valid=1, upd_taken=0, count=0 (0x0104 flushed).
- Target mispredict: pred taken → 0x0300, actual taken → 0x0340 → redirect_pc=0x0340, upd_target=0x0340, upd_taken=1.
- Simultaneous events:
  - Count=2, enq + correct resolve in the same cycle → count stays 2.
  - Enq + mispredicting resolve in the same cycle → count=0 and the enqueued PC never appears on upd_pc.
- Underflow and wrap:
  - res_valid on an empty queue → err_underflow=1, sticky; no pulses.
  - Run 10 enq/resolve pairs to cover pointer wrap past DEPTH → FIFO order preserved.
